gnr_node_param: RTL and testbench

GNR_NODE_PARAM -- requirements
Module: gnr_node_param

---
 rtl/gnr_node_param.sv | 140 ++++++++++++++
 tb/tb_gnr_node_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_node_param.sv
// Gene-regulatory-network node with two trajectories: a fast one (s1) that
// steps on every start_s1, and a slow one (s0) that steps on every
// SLOW_DIV-th start_s0. Mode 0 uses a boolean rule; mode 1 uses an
// activator/inhibitor popcount vote. Knockout and overexpression override
// the evaluated value on both trajectories.
module gnr_node_param #(
    parameter int unsigned NUM_ACT   = 4,
    parameter int unsigned NUM_INH   = 1,
    parameter int unsigned SLOW_DIV  = 2,
    parameter int unsigned RULE_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_nos,
    input  logic               init_state,
    input  logic               start_s0,
    input  logic               start_s1,
    input  logic [NUM_ACT-1:0] act_s0,
    input  logic [NUM_ACT-1:0] act_s1,
    input  logic [NUM_INH-1:0] inh_s0,
    input  logic [NUM_INH-1:0] inh_s1,
    input  logic               ko_en,
    input  logic               oe_en,
    output logic               s0,
    output logic               s1,
    output logic               chg_s0,
    output logic               chg_s1,
    output logic               match
);

    localparam int unsigned CA_W  = $clog2(NUM_ACT + 1);
    localparam int unsigned CI_W  = $clog2(NUM_INH + 1);
    localparam int unsigned CNT_W = (CA_W > CI_W) ? CA_W : CI_W;
    localparam int unsigned PH_W  = 4;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);
    // After a hard reset the slow phase starts at 1, so the first slow step
    // is skipped unless reset_nos realigns it.
    localparam logic [PH_W-1:0] PH_RST  = (SLOW_DIV > 1) ? PH_W'(1) : PH_W'(0);

    logic [PH_W-1:0] ph;
    logic            nxt_s0;
    logic            nxt_s1;
    logic            upd_s0;

    // Number of active activator inputs.
    function automatic logic [CNT_W-1:0] count_act(input logic [NUM_ACT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_ACT); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Number of active inhibitor inputs.
    function automatic logic [CNT_W-1:0] count_inh(input logic [NUM_INH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_INH); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Regulatory rule for one trajectory; cur is that trajectory's state.
    function automatic logic eval_rule(input logic [NUM_ACT-1:0] act,
                                       input logic [NUM_INH-1:0] inh,
                                       input logic               cur);
        logic [CNT_W-1:0] ca;
        logic [CNT_W-1:0] ci;
        logic             r;
        ca = count_act(act);
        ci = count_inh(inh);
        if (RULE_MODE == 0) begin
            r = (|act) & ~(|inh);
        end else if (ca > ci) begin
            r = 1'b1;
        end else if (ca < ci) begin
            r = 1'b0;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    // Evaluated next values with knockout taking priority over overexpression.
    always_comb begin
        nxt_s0 = eval_rule(act_s0, inh_s0, s0);
        nxt_s1 = eval_rule(act_s1, inh_s1, s1);
        if (ko_en) begin
            nxt_s0 = 1'b0;
            nxt_s1 = 1'b0;
        end else if (oe_en) begin
            nxt_s0 = 1'b1;
            nxt_s1 = 1'b1;
        end
        upd_s0 = start_s0 && (ph == '0);
    end

    // Fast trajectory state and change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            chg_s1 <= 1'b0;
        end else if (reset_nos) begin
            s1     <= init_state;
            chg_s1 <= 1'b0;
        end else begin
            chg_s1 <= start_s1 && (nxt_s1 != s1);
            if (start_s1) begin
                s1 <= nxt_s1;
            end
        end
    end

    // Slow trajectory state, change pulse and divider phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0     <= 1'b0;
            chg_s0 <= 1'b0;
            ph     <= PH_RST;
        end else if (reset_nos) begin
            s0     <= init_state;
            chg_s0 <= 1'b0;
            ph     <= '0;
        end else begin
            chg_s0 <= upd_s0 && (nxt_s0 != s0);
            if (upd_s0) begin
                s0 <= nxt_s0;
            end
            if (start_s0) begin
                ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
            end
        end
    end

    assign match = ~(s0 ^ s1);

endmodule

// File: tb/tb_gnr_node_param.sv
// Bench for gnr_node_param: three instances (mode 0 / div 2, mode 1 / div 3
// with two inhibitors, mode 0 / div 1) share stimulus; a per-node model is
// checked every cycle and directed literal expectations pin the model.
module tb_gnr_node_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reset_nos = 1'b0;
    logic       init_state = 1'b0;
    logic       start_s0 = 1'b0;
    logic       start_s1 = 1'b0;
    logic [3:0] act_s0 = '0;
    logic [3:0] act_s1 = '0;
    logic [1:0] inh_s0 = '0;
    logic [1:0] inh_s1 = '0;
    logic       ko_en = 1'b0;
    logic       oe_en = 1'b0;

    logic [2:0] d_s0, d_s1, d_c0, d_c1, d_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gnr_node_param #(.NUM_ACT(4), .NUM_INH(1), .SLOW_DIV(2), .RULE_MODE(0)) u0 (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .act_s0(act_s0), .act_s1(act_s1),
        .inh_s0(inh_s0[0:0]), .inh_s1(inh_s1[0:0]), .ko_en(ko_en), .oe_en(oe_en),
        .s0(d_s0[0]), .s1(d_s1[0]), .chg_s0(d_c0[0]), .chg_s1(d_c1[0]), .match(d_m[0]));

    gnr_node_param #(.NUM_ACT(4), .NUM_INH(2), .SLOW_DIV(3), .RULE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .act_s0(act_s0), .act_s1(act_s1),
        .inh_s0(inh_s0), .inh_s1(inh_s1), .ko_en(ko_en), .oe_en(oe_en),
        .s0(d_s0[1]), .s1(d_s1[1]), .chg_s0(d_c0[1]), .chg_s1(d_c1[1]), .match(d_m[1]));

    gnr_node_param #(.NUM_ACT(4), .NUM_INH(1), .SLOW_DIV(1), .RULE_MODE(0)) u2 (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .act_s0(act_s0), .act_s1(act_s1),
        .inh_s0(inh_s0[0:0]), .inh_s1(inh_s1[0:0]), .ko_en(ko_en), .oe_en(oe_en),
        .s0(d_s0[2]), .s1(d_s1[2]), .chg_s0(d_c0[2]), .chg_s1(d_c1[2]), .match(d_m[2]));

    // Model: per node, state values plus the ordinal of the next slow pulse.
    logic m_s0[3], m_s1[3], m_c0[3], m_c1[3];
    int   m_n[3];
    logic model_ok = 1'b0;

    function automatic int div_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction

    function automatic logic rule(int i, logic [3:0] a, logic [1:0] h, logic cur,
                                  logic ko, logic oe);
        int ca;
        int ci;
        ca = $countones(a);
        ci = (i == 1) ? $countones(h) : int'(h[0]);
        if (ko) return 1'b0;
        if (oe) return 1'b1;
        if (i != 1) return (ca > 0) && (ci == 0);
        if (ca > ci) return 1'b1;
        if (ca < ci) return 1'b0;
        return cur;
    endfunction

    // Advance the model on each rising edge from the inputs it sees.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic v0, v1;
            v0 = rule(i, act_s0, inh_s0, m_s0[i], ko_en, oe_en);
            v1 = rule(i, act_s1, inh_s1, m_s1[i], ko_en, oe_en);
            if (rst) begin
                m_s0[i] <= 1'b0; m_s1[i] <= 1'b0;
                m_c0[i] <= 1'b0; m_c1[i] <= 1'b0;
                m_n[i]  <= 1;
            end else if (reset_nos) begin
                m_s0[i] <= init_state; m_s1[i] <= init_state;
                m_c0[i] <= 1'b0; m_c1[i] <= 1'b0;
                m_n[i]  <= 0;
            end else begin
                m_c1[i] <= start_s1 && (v1 != m_s1[i]);
                if (start_s1) m_s1[i] <= v1;
                if (start_s0 && (m_n[i] % div_of(i) == 0)) begin
                    m_s0[i] <= v0;
                    m_c0[i] <= (v0 != m_s0[i]);
                end else begin
                    m_c0[i] <= 1'b0;
                end
                if (start_s0) m_n[i] <= m_n[i] + 1;
            end
        end
        model_ok <= 1'b1;
    end

    // Compare every node's outputs with the model on the falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (d_s0[i] !== m_s0[i] || d_s1[i] !== m_s1[i] || d_c0[i] !== m_c0[i] ||
                    d_c1[i] !== m_c1[i] || d_m[i] !== ~(m_s0[i] ^ m_s1[i])) begin
                    errors++;
                    $display("FAIL model u%0d t=%0t got s0=%b s1=%b c0=%b c1=%b m=%b want s0=%b s1=%b c0=%b c1=%b m=%b",
                             i, $time, d_s0[i], d_s1[i], d_c0[i], d_c1[i], d_m[i],
                             m_s0[i], m_s1[i], m_c0[i], m_c1[i], ~(m_s0[i] ^ m_s1[i]));
                end
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    // One clock: inputs as currently set, then strobes/resets drop.
    task automatic cyc();
        @(posedge clk);
        #2;
        rst = 1'b0; reset_nos = 1'b0; start_s0 = 1'b0; start_s1 = 1'b0;
    endtask

    initial begin
        cyc();
        chk("rst_s0", d_s0[0], 1'b0);
        chk("rst_s1", d_s1[0], 1'b0);
        chk("rst_chg0", d_c0[0], 1'b0);
        chk("rst_chg1", d_c1[0], 1'b0);

        // fast step toward 0 from init 1
        init_state = 1'b1; reset_nos = 1'b1; cyc();
        chk("nos_s1", d_s1[0], 1'b1);
        act_s1 = 4'b0000; inh_s1 = 2'b00; start_s1 = 1'b1; cyc();
        chk("r19_s1", d_s1[0], 1'b0);
        chk("r19_chg1", d_c1[0], 1'b1);
        chk("r19_match", d_m[0], 1'b0);
        cyc();
        chk("r19_chg1_drop", d_c1[0], 1'b0);

        // slow divider 2 after reset_nos
        init_state = 1'b0; reset_nos = 1'b1; cyc();
        act_s0 = 4'b0001; inh_s0 = 2'b00;
        for (int p = 1; p <= 4; p++) begin
            start_s0 = 1'b1; cyc();
            chk($sformatf("r20_s0_p%0d", p), d_s0[0], 1'b1);
            chk($sformatf("r20_chg0_p%0d", p), d_c0[0], p == 1);
            chk($sformatf("r20_div1_p%0d", p), d_s0[2], 1'b1);
            cyc();
        end

        // threshold rule with hold on tie
        init_state = 1'b1; reset_nos = 1'b1; cyc();
        act_s1 = 4'b0011; inh_s1 = 2'b11; start_s1 = 1'b1; cyc();
        chk("r21_tie", d_s1[1], 1'b1);
        chk("r21_tie_chg", d_c1[1], 1'b0);
        act_s1 = 4'b0001; start_s1 = 1'b1; cyc();
        chk("r21_less", d_s1[1], 1'b0);
        act_s1 = 4'b0111; start_s1 = 1'b1; cyc();
        chk("r21_more", d_s1[1], 1'b1);

        // overrides
        init_state = 1'b1; reset_nos = 1'b1; cyc();
        ko_en = 1'b1; oe_en = 1'b1; act_s0 = 4'b1111; act_s1 = 4'b1111;
        inh_s0 = 2'b00; inh_s1 = 2'b00; start_s0 = 1'b1; start_s1 = 1'b1; cyc();
        chk("r22_s0", d_s0[0], 1'b0);
        chk("r22_s1", d_s1[0], 1'b0);
        chk("r22_u1_s1", d_s1[1], 1'b0);
        ko_en = 1'b0; act_s1 = 4'b0000; inh_s1 = 2'b11; start_s1 = 1'b1; cyc();
        chk("oe_s1", d_s1[1], 1'b1);
        oe_en = 1'b0;

        // hard reset phase offset, divider 3
        rst = 1'b1; cyc();
        act_s0 = 4'b1111; inh_s0 = 2'b00;
        for (int p = 1; p <= 3; p++) begin
            start_s0 = 1'b1; cyc();
            chk($sformatf("r23_s0_p%0d", p), d_s0[1], p == 3);
        end
        act_s1 = 4'b1111; inh_s1 = 2'b00; start_s1 = 1'b1; cyc();
        chk("r23_s1_set", d_s1[1], 1'b1);
        rst = 1'b1; start_s1 = 1'b1; start_s0 = 1'b1; cyc();
        chk("r23_rst_s1", d_s1[1], 1'b0);
        chk("r23_rst_s0", d_s0[1], 1'b0);

        // reset_nos beats coincident strobes
        init_state = 1'b1; reset_nos = 1'b1; start_s0 = 1'b1; start_s1 = 1'b1;
        act_s0 = 4'b0000; act_s1 = 4'b0000; inh_s0 = 2'b01; inh_s1 = 2'b01; cyc();
        chk("r24_s0", d_s0[0], 1'b1);
        chk("r24_s1", d_s1[0], 1'b1);
        chk("r24_chg0", d_c0[0], 1'b0);
        chk("r24_chg1", d_c1[0], 1'b0);
        start_s0 = 1'b1; cyc();
        chk("r24_ph0", d_s0[0], 1'b0);
        chk("r24_ph0_chg", d_c0[0], 1'b1);

        // inputs without strobes have no effect
        act_s0 = 4'b1111; act_s1 = 4'b1111; inh_s0 = 2'b00; inh_s1 = 2'b00; cyc(); cyc();
        chk("nostrobe_s0", d_s0[0], 1'b0);
        chk("nostrobe_s1", d_s1[0], 1'b1);

        // mixed vectors, checked by the model
        for (int k = 0; k < 60; k++) begin
            rst = ($urandom_range(0, 29) == 0);
            reset_nos = ($urandom_range(0, 9) == 0);
            init_state = 1'($urandom);
            start_s0 = 1'($urandom); start_s1 = 1'($urandom);
            act_s0 = 4'($urandom); act_s1 = 4'($urandom);
            inh_s0 = 2'($urandom); inh_s1 = 2'($urandom);
            ko_en = ($urandom_range(0, 7) == 0); oe_en = ($urandom_range(0, 7) == 0);
            cyc();
        end
        ko_en = 1'b0; oe_en = 1'b0;
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
